// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with programmable depth and width, occupancy
// count, almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// and a choice of registered or first-word-fall-through read data.
//
// Handshake: wn is a write request and rn is a read request (pop). A request is
// accepted on the rising edge where it is presented and the FIFO can honour it:
// reads need a stored word (rd_ok = rn && !empty); writes need a free slot, and
// a same-edge accepted read counts as freeing one (wr_ok = wn && (!full || rd_ok)).
// A request that is not accepted has no effect on storage or pointers and sets
// the matching sticky error flag instead. There is no back-pressure output
// other than full/empty; the requester is expected to watch those.
module fifo_sync_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wn,
    input  logic                     rn,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     clr_err,
    output logic [DATA_W-1:0]        data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    // Reject configurations the pointer arithmetic and flag logic cannot honour.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two >= 2");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("fifo_sync_param: AFULL_TH must be in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sync_param: AEMPTY_TH must be in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("fifo_sync_param: FWFT must be 0 or 1");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              rd_ok;
    logic              wr_ok;

    // Status flags are pure decodes of the registered occupancy count.
    always_comb begin
        full         = (count == DEPTH_C);
        empty        = (count == '0);
        almost_full  = (count >= AFULL_C);
        almost_empty = (count <= AEMPTY_C);
    end

    // Acceptance: a full FIFO still takes a write when a read pops on the same edge.
    always_comb begin
        rd_ok = rn && !empty;
        wr_ok = wn && (!full || rd_ok);
    end

    // Storage array; contents survive reset and are only meaningful between pointers.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= data_in;
        end
    end

    // Pointers advance on accepted operations and wrap naturally (DEPTH is 2^AW).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
        end
    end

    // Occupancy: moves only when exactly one of write/read is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; clr_err wins over an error raised on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wn && !wr_ok) overflow  <= 1'b1;
            if (rn && !rd_ok) underflow <= 1'b1;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head of queue is presented directly; zero while nothing is stored.
        always_comb begin
            data_out = empty ? '0 : mem[rptr];
        end
    end else begin : g_std
        // Registered read: word appears the cycle after the accepting edge, then holds.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_out <= '0;
            end else if (rd_ok) begin
                data_out <= mem[rptr];
            end
        end
    end

endmodule
